pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen_pkg.sv | 16 +
 rtl/pc_gen_dff_set.sv | 21 ++
 rtl/pc_gen.sv | 109 ++++++++++
 tb/tb_pc_gen.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared PC step, default reset vector and fetch FSM encodings
package pc_gen_pkg;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_gen_dff_set.sv
// rtl/pc_gen_dff_set.sv - enabled register that loads a fixed value on synchronous reset
module dff_set #(
  parameter int unsigned      DW       = 32,
  parameter logic [DW-1:0]    SET_DATA = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] qout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      qout <= SET_DATA;
    end else if (en) begin
      qout <= din;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch program counter generator with ROM wait states, stall and redirect
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned ROM_WAIT     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic [31:0] pc_o,
  output logic        pc_valid_o,
  output logic        misalign_o
);

  localparam logic [3:0] WAIT_LOAD = 4'(ROM_WAIT);
  localparam logic [1:0] ST_FETCH  = (ROM_WAIT == 0) ? ST_RUN : ST_WAIT;

  logic [1:0]  state, state_n;
  logic [1:0]  ret_state, ret_state_n;
  logic [3:0]  wait_cnt, wait_cnt_n;
  logic [31:0] pc_n;
  logic        pc_en;
  logic        misalign_n;

  dff_set #(
    .DW       (32),
    .SET_DATA (RESET_VECTOR)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .en   (pc_en),
    .din  (pc_n),
    .qout (pc_o)
  );

  // In WAIT the counter runs ROM_WAIT..0, so every address is live ROM_WAIT+1 cycles
  always_comb begin
    state_n     = state;
    ret_state_n = ret_state;
    wait_cnt_n  = wait_cnt;
    pc_n        = pc_o;
    pc_en       = 1'b0;
    misalign_n  = 1'b0;
    if (jump_en_i) begin
      pc_n       = word_align(jump_addr_i);
      pc_en      = 1'b1;
      wait_cnt_n = WAIT_LOAD;
      state_n    = ST_FETCH;
      misalign_n = |jump_addr_i[1:0];
    end else begin
      case (state)
        ST_BOOT: begin
          state_n    = ST_FETCH;
          wait_cnt_n = WAIT_LOAD;
        end
        ST_RUN: begin
          if (hold_flag_i) begin
            ret_state_n = ST_RUN;
            state_n     = ST_HOLD;
          end else if (ROM_WAIT == 0) begin
            pc_n  = pc_o + PC_STEP;
            pc_en = 1'b1;
          end else begin
            state_n    = ST_WAIT;
            wait_cnt_n = WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (hold_flag_i) begin
            ret_state_n = ST_WAIT;
            state_n     = ST_HOLD;
          end else if (wait_cnt == 4'd0) begin
            pc_n       = pc_o + PC_STEP;
            pc_en      = 1'b1;
            wait_cnt_n = WAIT_LOAD;
          end else begin
            wait_cnt_n = wait_cnt - 4'd1;
          end
        end
        ST_HOLD: begin
          if (!hold_flag_i) begin
            state_n = ret_state;
          end
        end
        default: state_n = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_BOOT;
      ret_state  <= ST_RUN;
      wait_cnt   <= WAIT_LOAD;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_n;
      ret_state  <= ret_state_n;
      wait_cnt   <= wait_cnt_n;
      misalign_o <= misalign_n;
    end
  end

  assign pc_valid_o = (state != ST_BOOT);

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen with zero and two ROM wait states
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jump_en_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_i = 1'b0;
  logic [31:0] pc0, pc2;
  logic        v0, v2, m0, m2;

  always #5 clk = ~clk;

  pc_gen #(.RESET_VECTOR(32'h0000_0000), .ROM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .pc_o(pc0), .pc_valid_o(v0), .misalign_o(m0)
  );

  pc_gen #(.RESET_VECTOR(32'h0000_0000), .ROM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .pc_o(pc2), .pc_valid_o(v2), .misalign_o(m2)
  );

  logic [31:0] pc_a [2];
  logic        v_a  [2];
  logic        m_a  [2];
  assign pc_a[0] = pc0;
  assign pc_a[1] = pc2;
  assign v_a[0]  = v0;
  assign v_a[1]  = v2;
  assign m_a[0]  = m0;
  assign m_a[1]  = m2;

  // Reference: an address stays live for wait+1 unstalled cycles; a stall also costs its release edge
  int          rw [2] = '{0, 2};
  logic [31:0] m_pc   [2];
  bit          m_live [2];
  bit          m_frz  [2];
  bit          m_mis  [2];
  int          m_age  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_pc[d] = 32'h0; m_live[d] = 0; m_age[d] = 0; m_frz[d] = 0; m_mis[d] = 0;
      end else if (jump_en_i) begin
        m_pc[d] = jump_addr_i - (jump_addr_i % 4);
        m_live[d] = 1; m_age[d] = 0; m_frz[d] = 0;
        m_mis[d] = (jump_addr_i % 4) != 0;
      end else begin
        m_mis[d] = 0;
        if (!m_live[d]) begin
          m_live[d] = 1; m_age[d] = 0;
        end else if (m_frz[d]) begin
          m_frz[d] = hold_flag_i;
        end else if (hold_flag_i) begin
          m_frz[d] = 1;
        end else if (m_age[d] == rw[d]) begin
          m_pc[d] = m_pc[d] + 4; m_age[d] = 0;
        end else begin
          m_age[d] = m_age[d] + 1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; jump_en_i = 1; jump_addr_i = 32'h1234_5677; hold_flag_i = 1;
    tick();
    jump_en_i = 0; hold_flag_i = 0;
    tick();
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (pc_a[d] !== 32'h0) begin n_fail++; $display("FAIL reset_pc dut%0d got %h exp 00000000", d, pc_a[d]); end
      n_cmp++; if (v_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_valid dut%0d got %b exp 0", d, v_a[d]); end
      n_cmp++; if (m_a[d] !== 1'b0) begin n_fail++; $display("FAIL reset_misalign dut%0d got %b exp 0", d, m_a[d]); end
    end
  endtask

  task automatic test_boot();
    logic [31:0] e0, e2;
    rst = 0;
    for (int i = 1; i <= 9; i++) begin
      tick();
      e0 = 32'((i - 1) * 4);
      e2 = 32'(((i - 1) / 3) * 4);
      n_cmp++; if (pc0 !== e0) begin n_fail++; $display("FAIL boot_seq_w0 cyc%0d got %h exp %h", i, pc0, e0); end
      n_cmp++; if (pc2 !== e2) begin n_fail++; $display("FAIL boot_seq_w2 cyc%0d got %h exp %h", i, pc2, e2); end
      n_cmp++; if ({v0, v2} !== 2'b11) begin n_fail++; $display("FAIL boot_valid cyc%0d got %b%b exp 11", i, v0, v2); end
    end
  endtask

  task automatic test_hold();
    rst = 1; tick(); rst = 0;
    tick(); tick(); tick();
    n_cmp++; if (pc0 !== 32'h8) begin n_fail++; $display("FAIL hold_pre got %h exp 00000008", pc0); end
    hold_flag_i = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (pc0 !== 32'h8) begin n_fail++; $display("FAIL hold_frozen_w0 k%0d got %h exp 00000008", k, pc0); end
      n_cmp++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL hold_frozen_w2 k%0d got %h exp 00000000", k, pc2); end
    end
    hold_flag_i = 0;
    tick();
    n_cmp++; if (pc0 !== 32'h8) begin n_fail++; $display("FAIL hold_release_w0 got %h exp 00000008", pc0); end
    n_cmp++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL hold_release_w2 got %h exp 00000000", pc2); end
    tick();
    n_cmp++; if (pc0 !== 32'hC) begin n_fail++; $display("FAIL hold_resume_w0 got %h exp 0000000c", pc0); end
    n_cmp++; if (pc2 !== 32'h4) begin n_fail++; $display("FAIL hold_resume_w2 got %h exp 00000004", pc2); end
  endtask

  task automatic test_jump_hold();
    jump_en_i = 1; jump_addr_i = 32'h0000_1003; hold_flag_i = 1;
    tick();
    jump_en_i = 0; hold_flag_i = 0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if (pc_a[d] !== 32'h1000) begin n_fail++; $display("FAIL jump_pc dut%0d got %h exp 00001000", d, pc_a[d]); end
      n_cmp++; if (m_a[d] !== 1'b1) begin n_fail++; $display("FAIL jump_misalign dut%0d got %b exp 1", d, m_a[d]); end
      n_cmp++; if (v_a[d] !== 1'b1) begin n_fail++; $display("FAIL jump_valid dut%0d got %b exp 1", d, v_a[d]); end
    end
    tick();
    n_cmp++; if (pc0 !== 32'h1004) begin n_fail++; $display("FAIL jump_next_w0 got %h exp 00001004", pc0); end
    n_cmp++; if (pc2 !== 32'h1000) begin n_fail++; $display("FAIL jump_next_w2 got %h exp 00001000", pc2); end
    n_cmp++; if ({m0, m2} !== 2'b00) begin n_fail++; $display("FAIL misalign_pulse got %b%b exp 00", m0, m2); end
  endtask

  task automatic test_wrap();
    jump_en_i = 1; jump_addr_i = 32'hFFFF_FFFC;
    tick();
    jump_en_i = 0;
    n_cmp++; if (pc0 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_top got %h exp fffffffc", pc0); end
    n_cmp++; if (m0 !== 1'b0) begin n_fail++; $display("FAIL wrap_misalign got %b exp 0", m0); end
    tick();
    n_cmp++; if (pc0 !== 32'h0) begin n_fail++; $display("FAIL wrap_w0 got %h exp 00000000", pc0); end
    tick(); tick();
    n_cmp++; if (pc2 !== 32'h0) begin n_fail++; $display("FAIL wrap_w2 got %h exp 00000000", pc2); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e0, e2;
    jump_en_i = 1; jump_addr_i = 32'h0000_0040;
    tick();
    jump_en_i = 0;
    tick();
    rst = 1; hold_flag_i = 1; jump_en_i = 1; jump_addr_i = 32'h0000_0081;
    tick();
    jump_en_i = 0;
    for (int d = 0; d < 2; d++) begin
      n_cmp++; if ({pc_a[d], v_a[d], m_a[d]} !== {32'h0, 2'b00}) begin
        n_fail++; $display("FAIL rst_mid dut%0d got pc=%h v=%b m=%b exp pc=00000000 v=0 m=0", d, pc_a[d], v_a[d], m_a[d]);
      end
    end
    rst = 0; hold_flag_i = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      e0 = 32'((i - 1) * 4);
      e2 = (i <= 3) ? 32'h0 : 32'h4;
      n_cmp++; if (pc0 !== e0) begin n_fail++; $display("FAIL rst_reboot_w0 cyc%0d got %h exp %h", i, pc0, e0); end
      n_cmp++; if (pc2 !== e2) begin n_fail++; $display("FAIL rst_reboot_w2 cyc%0d got %h exp %h", i, pc2, e2); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom % 40) == 0;
      jump_en_i   = ($urandom % 6) == 0;
      hold_flag_i = ($urandom % 3) == 0;
      jump_addr_i = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        n_cmp++; if (pc_a[d] !== m_pc[d]) begin n_fail++; $display("FAIL rand_pc dut%0d n%0d got %h exp %h", d, n, pc_a[d], m_pc[d]); end
        n_cmp++; if (v_a[d] !== m_live[d]) begin n_fail++; $display("FAIL rand_valid dut%0d n%0d got %b exp %b", d, n, v_a[d], m_live[d]); end
        n_cmp++; if (m_a[d] !== m_mis[d]) begin n_fail++; $display("FAIL rand_misalign dut%0d n%0d got %b exp %b", d, n, m_a[d], m_mis[d]); end
        n_cmp++; if (pc_a[d][1:0] !== 2'b00) begin n_fail++; $display("FAIL rand_align dut%0d n%0d got %b exp 00", d, n, pc_a[d][1:0]); end
      end
    end
    rst = 0; jump_en_i = 0; hold_flag_i = 0;
  endtask

  initial begin
    test_reset();
    test_boot();
    test_hold();
    test_jump_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
